// File: rtl/alu_pkg.sv
// Shared types for the ALU controller and the sequential execute unit.
// Operation codes, execute-unit FSM states and the default datapath width.
package alu_pkg;

  localparam int ALU_DATA_W = 32;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0011,
    ALU_SLL = 4'b0100,
    ALU_SRL = 4'b0101,
    ALU_SRA = 4'b0111,
    ALU_EQ  = 4'b1000,
    ALU_XOR = 4'b1001,
    ALU_NE  = 4'b1010,
    ALU_SLT = 4'b1100,
    ALU_GE  = 4'b1101,
    ALU_LT  = 4'b1110
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_shifter.sv
// Iterative one-bit-per-cycle shifter used by alu_exec_seq when ALU_FAST_SHIFT_EN
// is not defined. o_step_data is the value after the current step; o_last flags the final step.
module alu_shifter #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_left,
  input  logic              i_arith,
  input  logic [DATA_W-1:0] i_data,
  input  logic [SHAMT_W-1:0] i_shamt,
  output logic [DATA_W-1:0] o_step_data,
  output logic              o_last
);

  logic [DATA_W-1:0]  r_data;
  logic [SHAMT_W-1:0] r_cnt;
  logic               r_left;
  logic               r_arith;

  // SRA replicates the sign bit; SRL and SLL shift in zeros.
  assign o_step_data = r_left ? {r_data[DATA_W-2:0], 1'b0}
                              : {r_arith & r_data[DATA_W-1], r_data[DATA_W-1:1]};
  assign o_last = (r_cnt == SHAMT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= '0;
      r_cnt   <= '0;
      r_left  <= 1'b0;
      r_arith <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_cnt   <= i_shamt;
      r_left  <= i_left;
      r_arith <= i_arith;
    end else if (r_cnt != '0) begin
      r_data <= o_step_data;
      r_cnt  <= r_cnt - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_exec_seq.sv
// Sequential execute unit: single-cycle logic/arith/compare ops, iterative shifts.
// Define ALU_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module alu_exec_seq
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        operation,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output alu_state_e        o_dbg_state
);

  localparam int SHAMT_W = $clog2(DATA_W);

  // Handshake: a request transfers on a rising edge where in_valid && in_ready;
  // a result transfers where out_valid && out_ready. result is stable while out_valid waits.
  alu_state_e         r_state, w_state_next;
  logic [DATA_W-1:0]  r_result, w_result_next, w_alu_res, w_step_data;
  logic [SHAMT_W-1:0] w_shamt;
  logic               w_accept, w_go_shift, w_last;
  alu_op_e            w_op;

  assign w_op    = alu_op_e'(operation);
  assign w_shamt = src_b[SHAMT_W-1:0];

  always_comb begin
    w_alu_res = '0;
    case (w_op)
      ALU_AND:        w_alu_res = src_a & src_b;
      ALU_OR:         w_alu_res = src_a | src_b;
      ALU_XOR:        w_alu_res = src_a ^ src_b;
      ALU_ADD:        w_alu_res = src_a + src_b;
      ALU_SUB:        w_alu_res = src_a - src_b;
      ALU_SLT,
      ALU_LT:         w_alu_res[0] = $signed(src_a) < $signed(src_b);
      ALU_GE:         w_alu_res[0] = $signed(src_a) >= $signed(src_b);
      ALU_EQ:         w_alu_res[0] = (src_a == src_b);
      ALU_NE:         w_alu_res[0] = (src_a != src_b);
`ifdef ALU_FAST_SHIFT_EN
      ALU_SLL:        w_alu_res = src_a << w_shamt;
      ALU_SRL:        w_alu_res = src_a >> w_shamt;
      ALU_SRA:        w_alu_res = $signed(src_a) >>> w_shamt;
`else
      // Only the zero-amount case completes directly; others go through the shifter.
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:        w_alu_res = src_a;
`endif
      default:        w_alu_res = '0;
    endcase
  end

`ifdef ALU_FAST_SHIFT_EN
  assign w_go_shift  = 1'b0;
  assign w_last      = 1'b0;
  assign w_step_data = '0;
`else
  logic w_is_shift;
  assign w_is_shift = (w_op == ALU_SLL) || (w_op == ALU_SRL) || (w_op == ALU_SRA);
  assign w_go_shift = w_is_shift && (w_shamt != '0);

  alu_shifter #(
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_accept && w_go_shift),
    .i_left      (w_op == ALU_SLL),
    .i_arith     (w_op == ALU_SRA),
    .i_data      (src_a),
    .i_shamt     (w_shamt),
    .o_step_data (w_step_data),
    .o_last      (w_last)
  );
`endif

  always_comb begin
    w_state_next  = r_state;
    w_result_next = r_result;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    case (r_state)
      ST_IDLE: in_ready = 1'b1;
      ST_SHIFT: begin
        if (w_last) begin
          w_state_next  = ST_DONE;
          w_result_next = w_step_data;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
    // An accepted request overrides the DONE->IDLE move for back-to-back issue.
    w_accept = in_valid && in_ready;
    if (w_accept) begin
      if (w_go_shift) begin
        w_state_next = ST_SHIFT;
      end else begin
        w_state_next  = ST_DONE;
        w_result_next = w_alu_res;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_result <= '0;
    end else begin
      r_state  <= w_state_next;
      r_result <= w_result_next;
    end
  end

  assign result      = r_result;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_exec_seq.sv
// Bench for alu_exec_seq: directed plan items plus randomized traffic against a reference model,
// with a scoreboard checking result values and output latency.
module tb_alu_exec_seq;
  import alu_pkg::*;

  localparam int W = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] operation = 4'h0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [W-1:0] result;
  alu_state_e dbg_state;

  int unsigned cyc = 0;
  int n_vec = 0;
  int n_cmp = 0;
  int n_err = 0;
  bit rand_rdy = 1'b0;
  bit new_item = 1'b1;

  logic [W-1:0] exp_q[$];
  int unsigned  exp_cyc_q[$];

  alu_exec_seq #(.DATA_W(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .operation   (operation),
    .src_a       (src_a),
    .src_b       (src_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    n_cmp++;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_model(input logic [3:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    int sh;
    logic signed [W-1:0] sa, sb;
    sh = int'(b[4:0]);
    sa = a;
    sb = b;
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0011: return a - b;
      4'b0100: return a << sh;
      4'b0101: return a >> sh;
      4'b0111: return sa >>> sh;
      4'b1001: return a ^ b;
      4'b1100: return (sa < sb) ? 1 : 0;
      4'b1000: return (a == b) ? 1 : 0;
      4'b1010: return (a != b) ? 1 : 0;
      4'b1110: return (sa < sb) ? 1 : 0;
      4'b1101: return (sa >= sb) ? 1 : 0;
      default: return '0;
    endcase
  endfunction

  // Edges between acceptance and the first cycle with out_valid high.
  function automatic int unsigned ref_lat(input logic [3:0] op, input logic [W-1:0] b);
`ifdef ALU_FAST_SHIFT_EN
    return 0;
`else
    if (op == 4'b0100 || op == 4'b0101 || op == 4'b0111) return int'(b[4:0]);
    return 0;
`endif
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; inputs change at the falling edge, sampled 4ns later.
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      output int unsigned acc);
    int guard;
    guard = 0;
    acc = 0;
    in_valid = 1'b1;
    operation = op;
    src_a = a;
    src_b = b;
    #4;
    while (!in_ready) begin
      @(negedge clk);
      #4;
      guard++;
      if (guard > 200) begin
        n_cmp++;
        n_err++;
        $display("FAIL accept_timeout: in_ready low for %0d cycles, want acceptance", guard);
        @(negedge clk);
        in_valid = 1'b0;
        return;
      end
    end
    acc = cyc + 1;
    exp_q.push_back(ref_model(op, a, b));
    exp_cyc_q.push_back(acc + ref_lat(op, b));
    n_vec++;
    @(negedge clk);
    in_valid = 1'b0;
    operation = 4'($urandom());
    src_a = $urandom();
    src_b = $urandom();
  endtask

  task automatic drain();
    int g;
    g = 0;
    #4;
    while ((exp_q.size() != 0 || out_valid) && g < 3000) begin
      @(negedge clk);
      #4;
      g++;
    end
    if (g >= 3000) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, want 0", exp_q.size());
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    #4;
    if (reset) begin
      new_item = 1'b1;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious_out: result %h presented, want no output", result);
      end else begin
        if (new_item) begin
          chk("latency_cycle", W'(cyc), W'(exp_cyc_q[0]));
          new_item = 1'b0;
        end
        if (out_ready) begin
          chk("result", result, exp_q.pop_front());
          void'(exp_cyc_q.pop_front());
          new_item = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int unsigned acc1, acc2;
    logic [W-1:0] or_a, or_b;
    logic [3:0] rop;
    logic [W-1:0] ra, rb;

    repeat (2) @(negedge clk);
    reset = 1'b0;
    #4;
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_result", result, '0);
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_state", W'(dbg_state), W'(ST_IDLE));
    @(negedge clk);

    // directed plan items under continuous out_ready
    out_ready = 1'b1;
    send(ALU_ADD, 32'd5, 32'd7, acc1);
    send(ALU_ADD, 32'd9, 32'd1, acc2);
    chk("b2b_accept_edge", W'(acc2), W'(acc1 + 1));
    send(ALU_SUB, 32'd3, 32'd5, acc1);
    send(ALU_XOR, 32'hF0F0_0000, 32'hFFFF_0000, acc1);
    send(ALU_SRA, 32'h8000_0000, 32'd4, acc1);
    send(ALU_SLL, 32'd1, 32'd0, acc1);
    send(ALU_SRL, 32'h8000_0000, 32'd31, acc1);
    send(ALU_LT, 32'hFFFF_FFFF, 32'd1, acc1);
    send(ALU_GE, 32'hFFFF_FFFF, 32'd1, acc1);
    send(ALU_SLT, 32'hFFFF_FFFF, 32'd1, acc1);
    send(ALU_EQ, 32'd7, 32'd7, acc1);
    send(ALU_NE, 32'd7, 32'd7, acc1);
    send(4'b1111, 32'h1234_5678, 32'h0000_0003, acc1);
    send(4'b0110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, acc1);
    send(4'b1011, 32'hA5A5_A5A5, 32'h5A5A_5A5A, acc1);
    drain();

    // backpressure: result and out_valid hold, in_ready low
    out_ready = 1'b0;
    or_a = 32'h00FF_0F00;
    or_b = 32'h1200_00A5;
    send(ALU_OR, or_a, or_b, acc1);
    for (int i = 0; i < 3; i++) begin
      #4;
      chk("bp_out_valid", W'(out_valid), W'(1));
      chk("bp_result", result, or_a | or_b);
      chk("bp_in_ready", W'(in_ready), W'(0));
      @(negedge clk);
    end
    out_ready = 1'b1;
    #4;
    chk("bp_release_in_ready", W'(in_ready), W'(1));
    @(negedge clk);
    #4;
    chk("bp_after_out_valid", W'(out_valid), W'(0));
    chk("bp_after_in_ready", W'(in_ready), W'(1));
    @(negedge clk);

    // reset in the middle of a long shift
    send(ALU_SLL, 32'h0000_00F1, 32'd31, acc1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    exp_cyc_q.delete();
    @(negedge clk);
    reset = 1'b0;
    #4;
    chk("abort_out_valid", W'(out_valid), W'(0));
    chk("abort_result", result, '0);
    chk("abort_in_ready", W'(in_ready), W'(1));
    @(negedge clk);
    send(ALU_ADD, 32'd1, 32'd1, acc1);
    drain();

    // randomized traffic with random backpressure and idle gaps
    rand_rdy = 1'b1;
    for (int n = 0; n < 250; n++) begin
      rop = 4'($urandom());
      ra = $urandom();
      rb = $urandom();
      if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) rb = ra;
      send(rop, ra, rb, acc1);
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
